// File: rtl/pim_mem_pkg.sv
// Shared types and widths for the PIM/core memory arbiter.
package pim_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_PIM  = 1'b1
    } req_id_t;

    // A cycle carries a request when either strobe or any mask bit is set.
    function automatic logic req_present(input logic rstrb, input logic [MASK_W-1:0] wmask);
        return rstrb | (|wmask);
    endfunction

endpackage

// File: rtl/pim_req_buffer.sv
// One-deep request buffer for a single requester, with its busy flags,
// overflow pulse and the read-data register returned to that requester.
module pim_req_buffer
    import pim_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [MASK_W-1:0] i_wmask,
    input  logic              i_rstrb,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic [MASK_W-1:0] o_wmask,
    output logic              o_is_read,
    output logic              o_rbusy,
    output logic              o_wbusy,
    output logic              o_drop,
    output logic [DATA_W-1:0] o_rdata
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_wmask;
    logic              r_is_read;
    logic              r_drop;
    logic [DATA_W-1:0] r_rdata;
    logic              w_req;

    assign w_req = req_present(i_rstrb, i_wmask);

    // Capture into an empty slot, flag arrivals at a full slot, and return
    // read data when the arbiter retires this requester's transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wmask   <= '0;
            r_is_read <= 1'b0;
            r_drop    <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_drop <= w_req & r_valid;
            if (i_clear) begin
                r_valid <= 1'b0;
                if (r_is_read) begin
                    r_rdata <= i_rdata;
                end
            end else if (w_req && !r_valid) begin
                r_valid   <= 1'b1;
                r_addr    <= i_addr;
                r_wdata   <= i_wdata;
                r_wmask   <= i_wmask;
                // Any mask bit makes it a write, even with the read strobe set.
                r_is_read <= (i_wmask == '0);
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_addr    = r_addr;
    assign o_wdata   = r_wdata;
    assign o_wmask   = r_wmask;
    assign o_is_read = r_is_read;
    assign o_rbusy   = r_valid & r_is_read;
    assign o_wbusy   = r_valid & ~r_is_read;
    assign o_drop    = r_drop;
    assign o_rdata   = r_rdata;

endmodule

// File: rtl/pim_mem_arbiter.sv
// Arbitrates the RISC-V core and the PIM engine onto a single ram_controller
// port: one buffered request per side, round-robin on ties, PIM-only under lock.
module pim_mem_arbiter
    import pim_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] riscv_addr,
    input  logic [DATA_W-1:0] riscv_wdata,
    input  logic [MASK_W-1:0] riscv_wmask,
    input  logic              riscv_rstrb,
    output logic [DATA_W-1:0] riscv_rdata,
    output logic              riscv_rbusy,
    output logic              riscv_wbusy,
    input  logic [ADDR_W-1:0] pim_addr,
    input  logic [DATA_W-1:0] pim_wdata,
    input  logic [MASK_W-1:0] pim_wmask,
    input  logic              pim_rstrb,
    output logic [DATA_W-1:0] pim_rdata,
    output logic              pim_rbusy,
    output logic              pim_wbusy,
    input  logic              pim_lock,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    output logic              mem_rstrb,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rbusy,
    input  logic              mem_wbusy,
    output logic              gnt_pim,
    output logic              drop_err
);

    arb_state_t        r_state;
    arb_state_t        w_next;
    req_id_t           r_gnt;
    req_id_t           r_last_grant;
    req_id_t           w_gnt_sel;
    logic              w_grant;
    logic              w_done;

    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [MASK_W-1:0] r_mem_wmask;
    logic              r_mem_rstrb;

    logic              w_core_valid, w_pim_valid;
    logic [ADDR_W-1:0] w_core_addr, w_pim_addr;
    logic [DATA_W-1:0] w_core_wdata, w_pim_wdata;
    logic [MASK_W-1:0] w_core_wmask, w_pim_wmask;
    logic              w_core_is_read, w_pim_is_read;
    logic              w_core_clear, w_pim_clear;
    logic              w_core_drop, w_pim_drop;

    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [MASK_W-1:0] w_sel_wmask;
    logic              w_sel_is_read;

    assign w_core_clear = w_done & (r_gnt == REQ_CORE);
    assign w_pim_clear  = w_done & (r_gnt == REQ_PIM);

    pim_req_buffer u_core_buf (
        .clk       (clk),
        .rst       (rst),
        .i_addr    (riscv_addr),
        .i_wdata   (riscv_wdata),
        .i_wmask   (riscv_wmask),
        .i_rstrb   (riscv_rstrb),
        .i_clear   (w_core_clear),
        .i_rdata   (mem_rdata),
        .o_valid   (w_core_valid),
        .o_addr    (w_core_addr),
        .o_wdata   (w_core_wdata),
        .o_wmask   (w_core_wmask),
        .o_is_read (w_core_is_read),
        .o_rbusy   (riscv_rbusy),
        .o_wbusy   (riscv_wbusy),
        .o_drop    (w_core_drop),
        .o_rdata   (riscv_rdata)
    );

    pim_req_buffer u_pim_buf (
        .clk       (clk),
        .rst       (rst),
        .i_addr    (pim_addr),
        .i_wdata   (pim_wdata),
        .i_wmask   (pim_wmask),
        .i_rstrb   (pim_rstrb),
        .i_clear   (w_pim_clear),
        .i_rdata   (mem_rdata),
        .o_valid   (w_pim_valid),
        .o_addr    (w_pim_addr),
        .o_wdata   (w_pim_wdata),
        .o_wmask   (w_pim_wmask),
        .o_is_read (w_pim_is_read),
        .o_rbusy   (pim_rbusy),
        .o_wbusy   (pim_wbusy),
        .o_drop    (w_pim_drop),
        .o_rdata   (pim_rdata)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant selection and next-state; lock is honoured only when choosing in IDLE.
    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_gnt_sel = REQ_CORE;
        w_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (pim_lock) begin
                    if (w_pim_valid) begin
                        w_grant   = 1'b1;
                        w_gnt_sel = REQ_PIM;
                    end
                end else if (w_core_valid && w_pim_valid) begin
                    w_grant   = 1'b1;
                    w_gnt_sel = (r_last_grant == REQ_PIM) ? REQ_CORE : REQ_PIM;
                end else if (w_core_valid) begin
                    w_grant   = 1'b1;
                    w_gnt_sel = REQ_CORE;
                end else if (w_pim_valid) begin
                    w_grant   = 1'b1;
                    w_gnt_sel = REQ_PIM;
                end
                if (w_grant) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (!mem_rbusy && !mem_wbusy) begin
                    w_done = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Mux the fields of whichever buffer is being granted.
    always_comb begin
        w_sel_addr    = w_core_addr;
        w_sel_wdata   = w_core_wdata;
        w_sel_wmask   = w_core_wmask;
        w_sel_is_read = w_core_is_read;
        if (w_gnt_sel == REQ_PIM) begin
            w_sel_addr    = w_pim_addr;
            w_sel_wdata   = w_pim_wdata;
            w_sel_wmask   = w_pim_wmask;
            w_sel_is_read = w_pim_is_read;
        end
    end

    // Downstream request registers: loaded on grant so the strobe lands in
    // ISSUE only; address/data hold afterwards. Round-robin pointer moves on retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wmask  <= '0;
            r_mem_rstrb  <= 1'b0;
            r_gnt        <= REQ_CORE;
            r_last_grant <= REQ_PIM;
        end else begin
            r_mem_rstrb <= 1'b0;
            r_mem_wmask <= '0;
            if (w_grant) begin
                r_gnt       <= w_gnt_sel;
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
                if (w_sel_is_read) begin
                    r_mem_rstrb <= 1'b1;
                end else begin
                    r_mem_wmask <= w_sel_wmask;
                end
            end
            if (w_done) begin
                r_last_grant <= r_gnt;
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wmask = r_mem_wmask;
    assign mem_rstrb = r_mem_rstrb;
    assign gnt_pim   = (r_gnt == REQ_PIM);
    assign drop_err  = w_core_drop | w_pim_drop;

endmodule
